// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared definitions for the MAR/MDR memory controller.
//   - state_e         : control FSM states (idle, request outstanding, done)
//   - POISON          : data written into MDR when a read is aborted by timeout
//   - TIMEOUT_DEFAULT : default number of request cycles before abort
//   The timeout path is only built when MEM_TIMEOUT_EN is defined.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [15:0] POISON          = 16'hDEAD;
   localparam int          TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
//   Loadable down-counter that bounds how long a memory request may stay
//   outstanding. Only instantiated when MEM_TIMEOUT_EN is defined.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     load   in  reload the counter with TIMEOUT (request accepted)
//     dec    in  decrement by one (request cycle without ack)
//     expire out the current request cycle is the last one allowed
module mem_timeout_cnt
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic expire
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The decrement that would take the count to zero is the abort edge, so a
   // request gets exactly TIMEOUT cycles (at least one when TIMEOUT is 0).
   assign expire = (cnt_q <= CW'(1));

endmodule

// File: rtl/mem_data_ctrl.sv
// mem_data_ctrl
//   MAR/MDR register pair plus the memory read/write handshake FSM.
//   Optional feature macro: MEM_TIMEOUT_EN (request timeout with sticky Fault).
//   Ports:
//     Clk, Reset_n        clock, asynchronous active-low reset
//     Bus                 datapath bus, source of MAR/MDR loads
//     LD_MAR, LD_MDR      register loads, honoured only while idle
//     MIO_EN              1 = memory transaction mode, 0 = bus-load mode
//     Start, WE           launch an access (WE=1 write, WE=0 read)
//     MDR_Out, MAR_Out    register contents
//     R                   one-cycle completion pulse
//     Busy                access in progress
//     Fault               sticky timeout flag (0 without MEM_TIMEOUT_EN)
//     MemReq, MemWE       registered request / write enable to memory
//     MemAddr, MemWData   address and write data to memory
//     MemRData, MemAck    read data and single-cycle completion from memory
//
//   Handshake: MemReq rises on the edge that accepts Start and stays high
//   until the edge that samples MemAck (or the timeout expires); MemWE,
//   MemAddr and MemWData are held constant for that whole interval. R is
//   high for the single cycle after completion.
module mem_data_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int N       = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [N-1:0]      Bus,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              MIO_EN,
   input  logic              Start,
   input  logic              WE,
   output logic [N-1:0]      MDR_Out,
   output logic [ADDR_W-1:0] MAR_Out,
   output logic              R,
   output logic              Busy,
   output logic              Fault,
   output logic              MemReq,
   output logic              MemWE,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [N-1:0]      MemWData,
   input  logic [N-1:0]      MemRData,
   input  logic              MemAck
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [N-1:0]      mdr_q, mdr_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] bus_addr;
   logic              start_ok;

   // MAR takes the low bus bits; a wider MAR is zero-filled.
   generate
      if (ADDR_W <= N) begin : g_addr_narrow
         assign bus_addr = Bus[ADDR_W-1:0];
      end else begin : g_addr_wide
         assign bus_addr = {{(ADDR_W-N){1'b0}}, Bus};
      end
   endgenerate

   assign start_ok = (state_q == S_IDLE) && Start && MIO_EN;

`ifdef MEM_TIMEOUT_EN
   localparam logic [N-1:0] POISON_N = N'(POISON);

   logic fault_q, fault_d;
   logic cnt_expire;

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .load   (start_ok),
      .dec    ((state_q == S_REQ) && !MemAck),
      .expire (cnt_expire)
   );
`endif

   always_comb begin
      state_d    = state_q;
      mar_d      = mar_q;
      mdr_d      = mdr_q;
      req_addr_d = req_addr_q;
      mem_req_d  = mem_req_q;
      mem_we_d   = mem_we_q;
`ifdef MEM_TIMEOUT_EN
      fault_d    = fault_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (LD_MAR) begin
               mar_d = bus_addr;
            end
            if (LD_MDR && !MIO_EN) begin
               mdr_d = Bus;
            end
            if (start_ok) begin
               // Capture the pre-edge MAR so a same-edge LD_MAR only affects
               // the next access.
               state_d    = S_REQ;
               mem_req_d  = 1'b1;
               mem_we_d   = WE;
               req_addr_d = mar_q;
            end
         end
         S_REQ: begin
            // Ack is checked first so it wins over a same-edge timeout.
            if (MemAck) begin
               if (!mem_we_q) begin
                  mdr_d = MemRData;
               end
               mem_req_d = 1'b0;
               state_d   = S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_expire) begin
               if (!mem_we_q) begin
                  mdr_d = POISON_N;
               end
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
               state_d   = S_DONE;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         mar_q      <= '0;
         mdr_q      <= '0;
         req_addr_q <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         mar_q      <= mar_d;
         mdr_q      <= mdr_d;
         req_addr_q <= req_addr_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
`ifdef MEM_TIMEOUT_EN
         fault_q    <= fault_d;
`endif
      end
   end

   assign MDR_Out  = mdr_q;
   assign MAR_Out  = mar_q;
   assign R        = (state_q == S_DONE);
   assign Busy     = (state_q != S_IDLE);
   assign MemReq   = mem_req_q;
   assign MemWE    = mem_we_q;
   // MAR cannot change while busy, so outside idle the captured address is
   // the MAR value the access was launched with.
   assign MemAddr  = (state_q == S_IDLE) ? mar_q : req_addr_q;
   assign MemWData = mdr_q;

`ifdef MEM_TIMEOUT_EN
   assign Fault = fault_q;
`else
   assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_data_ctrl.sv
// tb_mem_data_ctrl
//   Directed and randomized checks of mem_data_ctrl against a transaction-level
//   reference (expected MAR/MDR/Fault plus a queue of expected MDR results).
//   Timeout scenarios are included when MEM_TIMEOUT_EN is defined.
module tb_mem_data_ctrl;

   localparam int N  = 16;
   localparam int AW = 16;

   logic          Clk;
   logic          Reset_n;
   logic [N-1:0]  Bus;
   logic          LD_MAR;
   logic          LD_MDR;
   logic          MIO_EN;
   logic          Start;
   logic          WE;
   logic [N-1:0]  MDR_Out;
   logic [AW-1:0] MAR_Out;
   logic          R;
   logic          Busy;
   logic          Fault;
   logic          MemReq;
   logic          MemWE;
   logic [AW-1:0] MemAddr;
   logic [N-1:0]  MemWData;
   logic [N-1:0]  MemRData;
   logic          MemAck;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference state
   logic [AW-1:0] m_mar;
   logic [N-1:0]  m_mdr;
   logic          m_fault;
   logic [N-1:0]  exp_q[$];

   mem_data_ctrl #(
      .N      (N),
      .ADDR_W (AW),
      .TIMEOUT(15)
   ) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Bus      (Bus),
      .LD_MAR   (LD_MAR),
      .LD_MDR   (LD_MDR),
      .MIO_EN   (MIO_EN),
      .Start    (Start),
      .WE       (WE),
      .MDR_Out  (MDR_Out),
      .MAR_Out  (MAR_Out),
      .R        (R),
      .Busy     (Busy),
      .Fault    (Fault),
      .MemReq   (MemReq),
      .MemWE    (MemWE),
      .MemAddr  (MemAddr),
      .MemWData (MemWData),
      .MemRData (MemRData),
      .MemAck   (MemAck)
   );

   // ---------------- clock ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk1 ({tag, "_busy"},  Busy,    1'b0);
      chk1 ({tag, "_r"},     R,       1'b0);
      chk1 ({tag, "_req"},   MemReq,  1'b0);
      chk16({tag, "_mar"},   MAR_Out, m_mar);
      chk16({tag, "_mdr"},   MDR_Out, m_mdr);
      chk1 ({tag, "_fault"}, Fault,   m_fault);
   endtask

   // ---------------- drivers ----------------
   task automatic load_mar(input logic [AW-1:0] v);
      Bus = v; LD_MAR = 1'b1; MIO_EN = 1'b0;
      tick();
      LD_MAR = 1'b0;
      m_mar = v;
   endtask

   task automatic load_mdr(input logic [N-1:0] v);
      Bus = v; LD_MDR = 1'b1; MIO_EN = 1'b0;
      tick();
      LD_MDR = 1'b0;
      m_mdr = v;
   endtask

   // One complete access. wait_n = idle request cycles before the ack cycle.
   // noise drives loads and Start while busy, all of which must be ignored.
   task automatic txn(input logic we, input int wait_n, input logic [N-1:0] rdata,
                      input bit noise, input bit ld_with_start, input logic [AW-1:0] new_mar);
      logic [AW-1:0] exp_addr;
      logic [N-1:0]  exp_wdata;
      exp_addr  = m_mar;
      exp_wdata = m_mdr;
      exp_q.push_back(we ? m_mdr : rdata);
      MIO_EN = 1'b1; Start = 1'b1; WE = we; LD_MAR = ld_with_start; Bus = new_mar;
      tick();
      Start = 1'b0; LD_MAR = 1'b0;
      if (ld_with_start) m_mar = new_mar;
      for (int i = 0; i <= wait_n; i++) begin
         chk1 ("req_memreq", MemReq,   1'b1);
         chk1 ("req_memwe",  MemWE,    we);
         chk16("req_addr",   MemAddr,  exp_addr);
         chk16("req_wdata",  MemWData, exp_wdata);
         chk16("req_mar",    MAR_Out,  m_mar);
         chk1 ("req_r",      R,        1'b0);
         chk1 ("req_busy",   Busy,     1'b1);
         if (i == wait_n) begin
            MemAck = 1'b1; MemRData = rdata;
            LD_MAR = 1'b0; LD_MDR = 1'b0; Start = 1'b0;
         end else begin
            MemAck = 1'b0; MemRData = 16'($urandom);
            if (noise) begin
               LD_MAR = 1'b1; LD_MDR = 1'($urandom_range(0, 1));
               Start = 1'b1; WE = 1'($urandom_range(0, 1)); Bus = 16'($urandom);
            end
         end
         tick();
      end
      MemAck = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0; Start = 1'b0;
      chk1 ("done_r",      R,      1'b1);
      chk1 ("done_busy",   Busy,   1'b1);
      chk1 ("done_memreq", MemReq, 1'b0);
      m_mdr = exp_q.pop_front();
      chk16("done_mdr",    MDR_Out, m_mdr);
      chk16("done_mar",    MAR_Out, m_mar);
      if (noise) begin
         Start = 1'b1; WE = 1'($urandom_range(0, 1)); LD_MAR = 1'b1; Bus = 16'($urandom);
      end
      tick();
      Start = 1'b0; LD_MAR = 1'b0;
      chk_idle("after");
      tick();
      chk_idle("no_queue");
   endtask

   // ---------------- sequence ----------------
   initial begin
      Reset_n = 1'b0; Bus = '0; LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0;
      Start = 1'b0; WE = 1'b0; MemRData = '0; MemAck = 1'b0;
      m_mar = '0; m_mdr = '0; m_fault = 1'b0;
      tick();
      tick();
      chk1("rst_memwe", MemWE, 1'b0);
      chk_idle("rst");
      Reset_n = 1'b1;
      tick();

      // Bus loads
      load_mar(16'h3000);
      load_mdr(16'hABCD);
      chk_idle("bus_load");

      // LD_MDR in memory mode is ignored
      Bus = 16'h1111; LD_MDR = 1'b1; MIO_EN = 1'b1;
      tick();
      LD_MDR = 1'b0;
      chk_idle("ldmdr_mio");

      // Start with MIO_EN=0 is ignored
      MIO_EN = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      chk_idle("start_no_mio");

      // Stray ack while idle is ignored
      MemAck = 1'b1; MemRData = 16'h7777;
      tick();
      MemAck = 1'b0;
      chk_idle("stray_ack");

      // Read with ack on 3rd request cycle (Start to R = 4 cycles)
      txn(1'b0, 2, 16'h1234, 1'b0, 1'b0, '0);
      chk16("read_mdr", MDR_Out, 16'h1234);

      // Write with zero wait
      load_mdr(16'h5A5A);
      txn(1'b1, 0, 16'hFFFF, 1'b0, 1'b0, '0);
      chk16("write_mdr", MDR_Out, 16'h5A5A);

      // Loads and Start while busy are ignored
      txn(1'b0, 3, 16'h0F0F, 1'b1, 1'b0, '0);
      chk16("busy_mar", MAR_Out, 16'h3000);

      // LD_MAR together with Start: access uses the old MAR
      txn(1'b0, 1, 16'h2468, 1'b0, 1'b1, 16'h4000);
      chk16("same_edge_mar", MAR_Out, 16'h4000);

      // Randomized accesses
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 1) load_mar(16'($urandom));
         if ($urandom_range(0, 1) == 1) load_mdr(16'($urandom));
         txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      end

`ifdef MEM_TIMEOUT_EN
      // Ack on the expiring edge completes normally
      MIO_EN = 1'b1; Start = 1'b1; WE = 1'b0;
      tick();
      Start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         chk1("to_ack_req", MemReq, 1'b1);
         if (i == 15) begin MemAck = 1'b1; MemRData = 16'hBEEF; end
         tick();
      end
      MemAck = 1'b0;
      m_mdr = 16'hBEEF;
      chk1 ("to_ack_r",     R,       1'b1);
      chk1 ("to_ack_fault", Fault,   1'b0);
      chk16("to_ack_mdr",   MDR_Out, m_mdr);
      tick();
      chk_idle("to_ack_after");

      // No ack: abort after 15 request cycles
      Start = 1'b1; WE = 1'b0;
      tick();
      Start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         chk1("to_req",   MemReq, 1'b1);
         chk1("to_r",     R,      1'b0);
         chk1("to_fault", Fault,  1'b0);
         tick();
      end
      m_mdr = 16'hDEAD; m_fault = 1'b1;
      chk1 ("to_done_r",   R,       1'b1);
      chk1 ("to_done_req", MemReq,  1'b0);
      chk1 ("to_fault_set", Fault,  1'b1);
      chk16("to_poison",   MDR_Out, m_mdr);
      tick();
      chk_idle("to_after");
      tick();
      chk_idle("to_sticky");
`endif

      // Reset in the middle of a request
      MIO_EN = 1'b1; Start = 1'b1; WE = 1'b0;
      tick();
      Start = 1'b0;
      chk1("mid_req", MemReq, 1'b1);
      #2;
      Reset_n = 1'b0;
      #1;
      m_mar = '0; m_mdr = '0; m_fault = 1'b0;
      chk_idle("mid_rst");
      MemAck = 1'b1; MemRData = 16'h9999;
      tick();
      chk_idle("mid_rst_hold");
      Reset_n = 1'b1; MemAck = 1'b0;
      tick();
      chk_idle("mid_rst_release");
      tick();
      chk_idle("mid_rst_no_r");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
